// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states, default widths
// and duty end-point constants used by generator and capture.
package pwm_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int DUTY_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW
  } state_e;

  localparam logic [DUTY_W_DEF-1:0] DUTY_ONES = '1;
  localparam logic [DUTY_W_DEF-1:0] DUTY_ZERO = '0;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// Caller guarantees dividend[high part] < divisor so the quotient fits.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic                    i_Clock,
  input  logic                    i_Rst_n,
  input  logic                    i_Start,
  input  logic [CNT_W+DUTY_W-1:0] i_Dividend,
  input  logic [CNT_W-1:0]        i_Divisor,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic [DUTY_W-1:0]       o_Quotient
);

  localparam int IW = $clog2(DUTY_W + 1);

  logic              busy_q, busy_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [DUTY_W-1:0] low_q, low_d;
  logic [DUTY_W-2:0] quo_q, quo_d;

  logic [CNT_W:0]    shl;
  logic [CNT_W-1:0]  diff;
  logic              take;
  logic              last;

  always_comb begin
    shl  = {rem_q, low_q[DUTY_W-1]};
    diff = shl[CNT_W-1:0] - div_q;
    take = shl >= {1'b0, div_q};
    last = busy_q && (idx_q == IW'(DUTY_W - 1));
  end

  assign o_Busy     = busy_q;
  assign o_Done     = last;
  assign o_Quotient = {quo_q, take};

  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    rem_d  = rem_q;
    div_d  = div_q;
    low_d  = low_q;
    quo_d  = quo_q;
    if (!busy_q) begin
      if (i_Start) begin
        busy_d = 1'b1;
        idx_d  = '0;
        rem_d  = i_Dividend[CNT_W+DUTY_W-1:DUTY_W];
        low_d  = i_Dividend[DUTY_W-1:0];
        div_d  = i_Divisor;
        quo_d  = '0;
      end
    end else begin
      // remainder stays below divisor, so CNT_W bits hold it
      rem_d = take ? diff : shl[CNT_W-1:0];
      low_d = low_q << 1;
      quo_d = o_Quotient[DUTY_W-2:0];
      idx_d = idx_q + IW'(1);
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      low_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      low_q  <= low_d;
      quo_q  <= quo_d;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM feedback capture: high time, period and duty of i_Pwm,
// with stuck-high / stuck-low timeout flags.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Enable,
  input  logic              i_Pwm,
  output logic [DUTY_W-1:0] o_Duty,
  output logic [CNT_W-1:0]  o_High_Cnt,
  output logic [CNT_W-1:0]  o_Period_Cnt,
  output logic              o_Duty_DV,
  output logic              o_Stuck_High,
  output logic              o_Stuck_Low,
  output logic              o_Overrun
);

  localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [1:0]        sync_q;
  logic              dly_q;
  logic              pwm_s;
  logic              rise;
  logic              fall;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  hi_q, hi_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [CNT_W-1:0]  hic_q, hic_d;
  logic [CNT_W-1:0]  perc_q, perc_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dv_q, dv_d;
  logic              sh_q, sh_d;
  logic              sl_q, sl_d;
  logic              ovr_q, ovr_d;

  logic              to_hi;
  logic              to_lo;
  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [DUTY_W-1:0] div_quo;

  assign pwm_s = sync_q[1];
  assign rise  = pwm_s & ~dly_q;
  assign fall  = ~pwm_s & dly_q;

  pwm_duty_div #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_div (
    .i_Clock    (i_Clock),
    .i_Rst_n    (i_Rst_n),
    .i_Start    (div_start),
    .i_Dividend ({hi_q, {DUTY_W{1'b0}}}),
    .i_Divisor  (per_q),
    .o_Busy     (div_busy),
    .o_Done     (div_done),
    .o_Quotient (div_quo)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    per_d     = per_q;
    hic_d     = hic_q;
    perc_d    = perc_q;
    div_start = 1'b0;
    ovr_d     = 1'b0;
    to_hi     = 1'b0;
    to_lo     = 1'b0;
    if (!i_Enable) begin
      state_d = S_IDLE;
      hi_d    = '0;
      per_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          hi_d    = '0;
          per_d   = '0;
          state_d = S_ARM;
        end
        S_ARM: begin
          if (rise) begin
            state_d = S_HIGH;
            hi_d    = ONE;
            per_d   = ONE;
          end
        end
        S_HIGH: begin
          // the fall cycle is the first low cycle of the period
          if (fall) begin
            state_d = S_LOW;
            per_d   = per_q + ONE;
          end else if (hi_q == TO_C) begin
            to_hi   = 1'b1;
            state_d = S_ARM;
          end else begin
            hi_d  = hi_q + ONE;
            per_d = per_q + ONE;
          end
        end
        S_LOW: begin
          if (rise) begin
            if (div_busy) begin
              ovr_d = 1'b1;
            end else begin
              div_start = 1'b1;
              hic_d     = hi_q;
              perc_d    = per_q;
            end
            state_d = S_HIGH;
            hi_d    = ONE;
            per_d   = ONE;
          end else if ((per_q - hi_q) == TO_C) begin
            to_lo   = 1'b1;
            state_d = S_ARM;
          end else begin
            per_d = per_q + ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    duty_d = duty_q;
    dv_d   = 1'b0;
    if (div_done) begin
      duty_d = div_quo;
      dv_d   = 1'b1;
    end
    // a stuck report owns the duty over a finishing division
    if (to_hi) begin
      duty_d = '1;
      dv_d   = 1'b1;
    end else if (to_lo) begin
      duty_d = '0;
      dv_d   = 1'b1;
    end
    sh_d = to_hi ? 1'b1 : (fall ? 1'b0 : sh_q);
    sl_d = to_lo ? 1'b1 : (rise ? 1'b0 : sl_q);
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      sync_q  <= '0;
      dly_q   <= 1'b0;
      state_q <= S_IDLE;
      hi_q    <= '0;
      per_q   <= '0;
      hic_q   <= '0;
      perc_q  <= '0;
      duty_q  <= '0;
      dv_q    <= 1'b0;
      sh_q    <= 1'b0;
      sl_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_Pwm};
      dly_q   <= pwm_s;
      state_q <= state_d;
      hi_q    <= hi_d;
      per_q   <= per_d;
      hic_q   <= hic_d;
      perc_q  <= perc_d;
      duty_q  <= duty_d;
      dv_q    <= dv_d;
      sh_q    <= sh_d;
      sl_q    <= sl_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_Duty       = duty_q;
  assign o_High_Cnt   = hic_q;
  assign o_Period_Cnt = perc_q;
  assign o_Duty_DV    = dv_q;
  assign o_Stuck_High = sh_q;
  assign o_Stuck_Low  = sl_q;
  assign o_Overrun    = ovr_q;

endmodule
